// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Sole master of the register-file write port. It merges the in-order
//   MEM/WB writeback, which always wins, with a long-latency mul/div result
//   stream held in a one-entry buffer. It also tracks outstanding
//   long-latency destinations for the hazard unit and requests a stall when
//   the buffered result keeps losing the write slot.
//
// Ports
//   clk, reset                : clock, synchronous active-high reset
//   wb_valid/wb_rd/wb_memtoreg/wb_alu_result/wb_load_data : pipeline writeback
//   md_valid/md_ready/md_rd/md_data : long-latency result handshake
//   md_issue/md_issue_rd      : long-latency op issued (scoreboard set)
//   rf_we/rf_waddr/rf_wdata   : registered register-file write port
//   rf_src                    : 0 = pipeline write, 1 = long-latency write
//   pend_mask                 : per-register outstanding long-latency write
//   stall_req                 : buffered result starved, bubble the pipeline
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [ADDR_W-1:0]     wb_rd,
    input  logic                  wb_memtoreg,
    input  logic [DATA_W-1:0]     wb_alu_result,
    input  logic [DATA_W-1:0]     wb_load_data,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [ADDR_W-1:0]     md_rd,
    input  logic [DATA_W-1:0]     md_data,
    input  logic                  md_issue,
    input  logic [ADDR_W-1:0]     md_issue_rd,
    output logic                  rf_we,
    output logic [ADDR_W-1:0]     rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  rf_src,
    output logic [(1<<ADDR_W)-1:0] pend_mask,
    output logic                  stall_req
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic              buf_valid;
    logic [ADDR_W-1:0] buf_rd;
    logic [DATA_W-1:0] buf_data;
    logic [3:0]        starve_cnt;

    logic              pipe_wr;
    logic              drain;
    logic              xfer;
    logic [3:0]        cnt_nxt;
    logic [NREG-1:0]   pend_nxt;

    assign md_ready = !buf_valid;

    always_comb begin
        pipe_wr = wb_valid && (wb_rd != '0);
        // The buffer only gets the port on cycles the pipeline leaves free.
        drain   = buf_valid && !pipe_wr;
        xfer    = md_valid && !buf_valid;

        cnt_nxt = starve_cnt;
        if (drain)
            cnt_nxt = '0;
        else if (buf_valid && (starve_cnt != CNT_MAX))
            cnt_nxt = starve_cnt + 4'd1;

        // Clear first so a same-cycle issue to the same register wins.
        pend_nxt = pend_mask;
        if (drain)
            pend_nxt[buf_rd] = 1'b0;
        if (md_issue && (md_issue_rd != '0))
            pend_nxt[md_issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            rf_src     <= 1'b0;
            buf_valid  <= 1'b0;
            buf_rd     <= '0;
            buf_data   <= '0;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
            pend_mask  <= '0;
        end else begin
            if (pipe_wr) begin
                rf_we    <= 1'b1;
                rf_waddr <= wb_rd;
                rf_wdata <= wb_memtoreg ? wb_load_data : wb_alu_result;
                rf_src   <= 1'b0;
            end else if (drain && (buf_rd != '0)) begin
                rf_we    <= 1'b1;
                rf_waddr <= buf_rd;
                rf_wdata <= buf_data;
                rf_src   <= 1'b1;
            end else begin
                // Includes the silent drain of an r0 result.
                rf_we    <= 1'b0;
            end

            if (drain) begin
                buf_valid <= 1'b0;
            end else if (xfer) begin
                buf_valid <= 1'b1;
                buf_rd    <= md_rd;
                buf_data  <= md_data;
            end

            starve_cnt <= cnt_nxt;
            stall_req  <= (cnt_nxt == CNT_MAX);
            pend_mask  <= pend_nxt;
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Write-side master for the 32x32 register file. It owns the single write port: write_enable, write_address and write_data.
- Merges two writers onto that port:
  - the in-order MEM/WB pipeline writeback, which has absolute priority and never stalls;
  - a long-latency multiply/divide result stream, accepted through a valid/ready handshake and a one-entry holding buffer.
- Keeps a pending-write scoreboard for the hazard unit.
- Raises a stall request when the buffered long-latency result is starved of write slots.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (2**ADDR_W registers).
- STARVE_MAX, 4, consecutive blocked cycles before stall_req asserts (range 1..15).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- wb_valid  in  1  pipeline writeback instruction present in WB.
- wb_rd  in  ADDR_W  pipeline destination register.
- wb_memtoreg  in  1  1 selects wb_load_data, 0 selects wb_alu_result.
- wb_alu_result  in  DATA_W  ALU result.
- wb_load_data  in  DATA_W  load data.
- md_valid  in  1  long-latency result offered.
- md_ready  out  1  buffer empty, able to accept a result.
- md_rd  in  ADDR_W  long-latency destination register.
- md_data  in  DATA_W  long-latency result.
- md_issue  in  1  long-latency op issued this cycle.
- md_issue_rd  in  ADDR_W  destination of the issued op.
- rf_we  out  1  register file write_enable.
- rf_waddr  out  ADDR_W  register file write_address.
- rf_wdata  out  DATA_W  register file write_data.
- rf_src  out  1  source of the current write: 0 = pipeline, 1 = long-latency.
- pend_mask  out  2**ADDR_W  bit i = register i has an outstanding long-latency write.
- stall_req  out  1  to hazard unit: insert bubbles until the buffer drains.

Behaviour:
- Reset, synchronous with priority over all other inputs:
  - rf_we=0, rf_waddr=0, rf_wdata=0, rf_src=0;
  - buffer empty (md_ready=1), pend_mask=0, starvation counter=0, stall_req=0.
  - Reset mid-operation discards buffered data and clears the scoreboard.
- rf_* outputs are registered. Inputs sampled at edge N appear on rf_* during cycle N+1. The register file commits them on that cycle's negedge.
- Pipeline write:
  - Condition: wb_valid=1 and wb_rd!=0.
  - Next cycle: rf_we=1, rf_waddr=wb_rd, rf_wdata = wb_memtoreg ? wb_load_data : wb_alu_result, rf_src=0.
- A cycle is a free slot when wb_valid=0 or wb_rd=0. Writes to r0 are never issued.
- Handshake:
  - md_ready = !buf_valid, a pure function of state.
  - Transfer occurs when md_valid & md_ready at a posedge; md_rd and md_data are captured into the buffer.
  - md_data must be held by the sender until the transfer.
- Drain:
  - Condition: buf_valid and a free slot in the same cycle.
  - Next cycle: rf_we=1, rf_waddr=buf_rd, rf_wdata=buf_data, rf_src=1; the buffer empties.
  - A buffered result with buf_rd=0 drains without asserting rf_we.
  - Minimum md-to-rf latency is 2 cycles. Sustained md throughput is 1 result per 2 cycles.
- Otherwise rf_we=0 next cycle. rf_waddr and rf_wdata hold their previous values.
- Starvation:
  - The counter increments each cycle that buf_valid=1 and no drain occurs, saturating at STARVE_MAX.
  - stall_req is registered and is 1 while counter==STARVE_MAX.
  - The counter clears to 0 on drain, so stall_req drops in the cycle after the drain.
- Scoreboard:
  - md_issue with md_issue_rd!=0 sets pend_mask[md_issue_rd] at the next edge.
  - A drain clears pend_mask[buf_rd].
  - If the same register is set and cleared in the same cycle, set wins.
  - Pipeline writes never modify pend_mask.
  - Issue to r0 is ignored.
- Simultaneous events:
  - Pipeline write and buffer drain cannot both issue. The pipeline wins and the buffer waits.
  - Transfer into the buffer and drain cannot occur in the same cycle, because ready requires an empty buffer.

Test Plan:
- Reset, then wb_valid=1, wb_rd=8, wb_memtoreg=0, alu=0x0000_1234 -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0x1234, rf_src=0. Repeat with wb_memtoreg=1, load=0xDEAD_BEEF -> rf_wdata=0xDEADBEEF.
- wb_valid=1, wb_rd=0 -> rf_we=0 next cycle. md_valid=1, md_rd=0 buffered -> drains, rf_we stays 0, md_ready returns to 1.
- Idle pipeline: md_issue rd=5 -> pend_mask=0x20. md_valid rd=5 data=0x77 accepted -> 2 cycles later rf_we=1, waddr=5, wdata=0x77, rf_src=1 -> pend_mask=0 the following cycle. md_ready=0 for exactly one cycle.
- Buffer holds rd=9 while wb_valid=1 with nonzero rd every cycle -> no md write, stall_req=1 after STARVE_MAX=4 blocked cycles. Drop wb_valid for one cycle -> md write issued next cycle, stall_req=0 one cycle after the drain.
- md_issue rd=3 in the same cycle the buffer drains rd=3 -> pend_mask[3] stays 1.
- Reset asserted with buffer full, pend_mask=0x0000_0120, stall_req=1 -> next cycle md_ready=1, pend_mask=0, stall_req=0, rf_we=0. The buffered result is never written.
